// File: rtl/dsp_pkg.sv
// Shared DSP constants and width helpers for the axis_arith / axis_frame_accum datapath.
package dsp_pkg;

  localparam int AXIS_ARITH_DATA_W = 32;
  localparam int NUM_LANES         = 2;

  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} accum_state_e;

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Bounds are returned wide; callers keep the low w bits.
  function automatic logic [127:0] sat_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_min(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/axis_frame_accum_if.sv
// Minimal AXI-Stream bundle (data/valid/ready/last) with master/slave views.
interface axis_frame_accum_if #(parameter int W = 64);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_sat_add.sv
// Signed saturating adder; ovf flags that the true sum was clipped.
module axis_sat_add
  import dsp_pkg::*;
#(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] SMAX = W'(sat_max(W));
  localparam logic [W-1:0] SMIN = W'(sat_min(W));

  logic [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};
  assign ovf  = full[W] ^ full[W-1];
  assign sum  = !ovf ? full[W-1:0] : (full[W] ? SMIN : SMAX);

endmodule

// File: rtl/axis_frame_accum.sv
// Per-frame two-lane saturating accumulator; emits one summary beat per frame.
module axis_frame_accum
  import dsp_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ACC_WIDTH  = 48,
  parameter  int MAX_LEN    = 1024,
  localparam int CNT_W      = cnt_w(MAX_LEN)
) (
  input  logic               aclk,
  input  logic               areset,
  axis_frame_accum_if.slave  s_axis,
  axis_frame_accum_if.master m_axis,
  output logic [CNT_W-1:0]   m_frame_len,
  output logic               m_frame_sat,
  output logic               m_frame_trunc
);

  typedef struct packed {
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0] sum;
    logic [CNT_W-1:0]                    len;
    logic                                sat;
    logic                                trunc;
  } frame_rpt_t;

  accum_state_e state, state_nxt;

  logic [NUM_LANES-1:0][ACC_WIDTH-1:0] acc_q, lane_ext, lane_sum;
  logic [NUM_LANES-1:0]                lane_ovf;
  logic [CNT_W-1:0]                    beat_cnt;
  logic                                sat_q, accept, close, frame_sat;
  frame_rpt_t                          rpt_q;

  // Ready looks straight through the output stage so back-to-back frames see no bubble.
  assign m_axis.tvalid = (state == ST_HOLD);
  assign m_axis.tlast  = m_axis.tvalid;
  assign s_axis.tready = (state != ST_HOLD) | m_axis.tready;

  assign accept    = s_axis.tvalid & s_axis.tready;
  assign close     = accept & (s_axis.tlast | (beat_cnt == CNT_W'(MAX_LEN - 1)));
  assign frame_sat = sat_q | (|lane_ovf);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ext[i] = ACC_WIDTH'($signed(s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH]));

    axis_sat_add #(.W(ACC_WIDTH)) u_add (
      .a   (acc_q[i]),
      .b   (lane_ext[i]),
      .sum (lane_sum[i]),
      .ovf (lane_ovf[i])
    );
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (close) state_nxt = ST_HOLD;
      ST_HOLD:  if (m_axis.tready && !close) state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_q    <= '0;
      beat_cnt <= '0;
      sat_q    <= 1'b0;
      rpt_q    <= '0;
    end else if (accept) begin
      if (close) begin
        // Closing beat lands in the report; running state restarts for the next frame.
        rpt_q.sum   <= lane_sum;
        rpt_q.len   <= beat_cnt + CNT_W'(1);
        rpt_q.sat   <= frame_sat;
        rpt_q.trunc <= ~s_axis.tlast;
        acc_q       <= '0;
        beat_cnt    <= '0;
        sat_q       <= 1'b0;
      end else begin
        acc_q    <= lane_sum;
        beat_cnt <= beat_cnt + CNT_W'(1);
        sat_q    <= frame_sat;
      end
    end
  end

  assign m_axis.tdata  = rpt_q.sum;
  assign m_frame_len   = rpt_q.len;
  assign m_frame_sat   = rpt_q.sat;
  assign m_frame_trunc = rpt_q.trunc;

endmodule
